// File: rtl/pdp11_pkg.sv
// Shared PDP-11 operand-fetch definitions: addressing modes, FSM states and step sizes.
package pdp11_pkg;

  localparam logic [2:0] MODE_REG         = 3'd0;
  localparam logic [2:0] MODE_REG_DEF     = 3'd1;
  localparam logic [2:0] MODE_AUTOINC     = 3'd2;
  localparam logic [2:0] MODE_AUTOINC_DEF = 3'd3;
  localparam logic [2:0] MODE_AUTODEC     = 3'd4;
  localparam logic [2:0] MODE_AUTODEC_DEF = 3'd5;
  localparam logic [2:0] MODE_INDEX       = 3'd6;
  localparam logic [2:0] MODE_INDEX_DEF   = 3'd7;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REG   = 3'd1;
  localparam logic [2:0] S_WB    = 3'd2;
  localparam logic [2:0] S_IDX   = 3'd3;
  localparam logic [2:0] S_PCWB  = 3'd4;
  localparam logic [2:0] S_DEFER = 3'd5;
  localparam logic [2:0] S_DATA  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] STEP_BYTE = 2'd1;
  localparam logic [1:0] STEP_WORD = 2'd2;

  localparam logic [2:0] REG_SP = 3'd6;
  localparam logic [2:0] REG_PC = 3'd7;

  // SP and PC always move by a word so they stay even; deferred modes step over a pointer.
  function automatic logic [1:0] step_size(input logic [2:0] mode, input logic byte_op,
                                           input logic [2:0] rn);
    if (byte_op && (rn < REG_SP) && (mode == MODE_AUTOINC || mode == MODE_AUTODEC))
      return STEP_BYTE;
    return STEP_WORD;
  endfunction

endpackage

// File: rtl/opnd_step.sv
// Combinational +/- step adder for auto-increment, auto-decrement and PC advance.
module opnd_step (
  input  logic [15:0] value,
  input  logic [1:0]  step,
  input  logic        dec,
  output logic [15:0] result
);

  logic [15:0] step_ext;

  assign step_ext = {14'd0, step};
  assign result   = dec ? (value - step_ext) : (value + step_ext);

endmodule

// File: rtl/operand_fetch.sv
// Resolves one PDP-11 operand specifier into an address and (optionally) its value,
// performing register side effects and memory reads through a single-request port.
module operand_fetch
  import pdp11_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  spec,
  input  logic        byte_op,
  input  logic        fetch,
  output logic [2:0]  rf_sel,
  input  logic [15:0] rf_data,
  output logic        rf_we,
  output logic [15:0] rf_w,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        is_reg,
  output logic [15:0] opnd_addr,
  output logic [15:0] opnd_val
);

  logic [2:0]  state_reg;
  logic [2:0]  mode_reg;
  logic [2:0]  rn_reg;
  logic        byte_reg;
  logic        fetch_reg;
  logic [15:0] base_reg;
  logic [15:0] pc_reg;
  logic [15:0] x_reg;
  logic [15:0] addr_reg;
  logic [15:0] val_reg;
  logic        is_reg_reg;
  logic        mem_req_reg;
  logic [15:0] mem_addr_reg;

  logic [15:0] step_value;
  logic [1:0]  step_amt;
  logic        step_dec;
  logic [15:0] step_result;
  logic [15:0] index_base;
  logic [2:0]  after_addr;

  // One adder serves both the register writeback and the PC advance.
  always_comb begin
    step_value = base_reg;
    step_amt   = step_size(mode_reg, byte_reg, rn_reg);
    step_dec   = (mode_reg == MODE_AUTODEC) || (mode_reg == MODE_AUTODEC_DEF);
    if (state_reg == S_PCWB) begin
      step_value = pc_reg;
      step_amt   = STEP_WORD;
      step_dec   = 1'b0;
    end
  end

  opnd_step u_step (
    .value  (step_value),
    .step   (step_amt),
    .dec    (step_dec),
    .result (step_result)
  );

  assign index_base = (rn_reg == REG_PC) ? step_result : base_reg;
  assign after_addr = fetch_reg ? S_DATA : S_DONE;

  assign rf_sel    = (state_reg == S_IDX || state_reg == S_PCWB) ? REG_PC : rn_reg;
  assign rf_we     = (state_reg == S_WB) || (state_reg == S_PCWB);
  assign rf_w      = rf_we ? step_result : 16'd0;
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_addr_reg;
  assign is_reg    = is_reg_reg;
  assign opnd_addr = addr_reg;
  assign opnd_val  = val_reg;

  // Memory states spend their first cycle issuing the request, so mem_req always
  // drops for at least one cycle between back-to-back accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      mode_reg     <= 3'd0;
      rn_reg       <= 3'd0;
      byte_reg     <= 1'b0;
      fetch_reg    <= 1'b0;
      base_reg     <= 16'd0;
      pc_reg       <= 16'd0;
      x_reg        <= 16'd0;
      addr_reg     <= 16'd0;
      val_reg      <= 16'd0;
      is_reg_reg   <= 1'b0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= 16'd0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          mode_reg   <= spec[5:3];
          rn_reg     <= spec[2:0];
          byte_reg   <= byte_op;
          fetch_reg  <= fetch;
          addr_reg   <= 16'd0;
          val_reg    <= 16'd0;
          is_reg_reg <= 1'b0;
          state_reg  <= S_REG;
        end
        S_REG: begin
          base_reg <= rf_data;
          case (mode_reg)
            MODE_REG: begin
              val_reg    <= rf_data;
              is_reg_reg <= 1'b1;
              state_reg  <= S_DONE;
            end
            MODE_REG_DEF: begin
              addr_reg  <= rf_data;
              state_reg <= after_addr;
            end
            MODE_INDEX, MODE_INDEX_DEF: state_reg <= S_IDX;
            default: state_reg <= S_WB;
          endcase
        end
        S_WB: begin
          addr_reg  <= step_dec ? step_result : base_reg;
          state_reg <= (mode_reg == MODE_AUTOINC_DEF || mode_reg == MODE_AUTODEC_DEF)
                       ? S_DEFER : after_addr;
        end
        S_IDX: if (!mem_req_reg) begin
          mem_req_reg  <= 1'b1;
          mem_addr_reg <= rf_data;
          pc_reg       <= rf_data;
        end else if (mem_ack) begin
          mem_req_reg <= 1'b0;
          x_reg       <= mem_rdata;
          state_reg   <= S_PCWB;
        end
        S_PCWB: begin
          addr_reg  <= index_base + x_reg;
          state_reg <= (mode_reg == MODE_INDEX_DEF) ? S_DEFER : after_addr;
        end
        S_DEFER: if (!mem_req_reg) begin
          mem_req_reg  <= 1'b1;
          mem_addr_reg <= addr_reg;
        end else if (mem_ack) begin
          mem_req_reg <= 1'b0;
          addr_reg    <= mem_rdata;
          state_reg   <= after_addr;
        end
        S_DATA: if (!mem_req_reg) begin
          mem_req_reg  <= 1'b1;
          mem_addr_reg <= addr_reg;
        end else if (mem_ack) begin
          mem_req_reg <= 1'b0;
          val_reg     <= mem_rdata;
          state_reg   <= S_DONE;
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a model register file and a delayed-ack memory.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  spec = 6'd0;
  logic        byte_op = 1'b0;
  logic        fetch = 1'b0;
  logic [2:0]  rf_sel;
  logic [15:0] rf_data;
  logic        rf_we;
  logic [15:0] rf_w;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'd0;
  logic        busy;
  logic        done;
  logic        is_reg;
  logic [15:0] opnd_addr;
  logic [15:0] opnd_val;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .spec      (spec),
    .byte_op   (byte_op),
    .fetch     (fetch),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .rf_we     (rf_we),
    .rf_w      (rf_w),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .is_reg    (is_reg),
    .opnd_addr (opnd_addr),
    .opnd_val  (opnd_val)
  );

  int tests = 0;
  int fails = 0;

  // Register file model: DUT writes win, otherwise the bench may preload a register.
  logic [15:0] regs [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [15:0] pl_val = 16'd0;
  int          we_count = 0;

  assign rf_data = regs[rf_sel];

  always @(posedge clk) begin
    if (rf_we) begin
      regs[rf_sel] <= rf_w;
      we_count     <= we_count + 1;
    end else if (pl_en) begin
      regs[pl_idx] <= pl_val;
    end
  end

  logic [15:0] mem [logic [15:0]];
  int          ack_delay = 0;
  int          ack_cnt = 0;
  int          req_cycles = 0;
  int          unstable = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = 16'd0;
  logic [15:0] last_ack_addr = 16'd0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] v);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = v;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Pulses start, then counts falling edges until done is seen; poke>0 pulses a
  // second start (spec 022) at that count while the first operation is busy.
  task automatic run_op(input logic [5:0] s, input logic b, input logic f, input int poke,
                        output int lat);
    int n;
    @(negedge clk);
    spec    = s;
    byte_op = b;
    fetch   = f;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (n == poke) begin
        start = 1'b1;
        spec  = 6'o22;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL timeout: observed done %b expected 1 within %0d cycles", done, n);
    end
    lat = n;
  endtask

  int lat;
  int r0;
  int w0;
  int u0;
  int n;

  initial begin
    // Memory responder: acks after ack_delay request cycles, drives inputs at negedge.
    fork
      forever begin
        @(negedge clk);
        if (mem_req) begin
          req_cycles++;
          if (prev_req && !prev_ack && mem_addr !== prev_addr) unstable++;
          if (ack_cnt == ack_delay) begin
            mem_ack       = 1'b1;
            mem_rdata     = mem.exists(mem_addr) ? mem[mem_addr] : 16'hDEAD;
            last_ack_addr = mem_addr;
            ack_cnt       = 0;
          end else begin
            mem_ack = 1'b0;
            ack_cnt++;
          end
        end else begin
          mem_ack = 1'b0;
          ack_cnt = 0;
        end
        prev_req  = mem_req;
        prev_addr = mem_addr;
        prev_ack  = mem_ack;
      end
    join_none

    mem[16'hFFFF] = 16'hA5A5;
    mem[16'h1000] = 16'h0010;
    mem[16'h2000] = 16'h3000;
    mem[16'h3000] = 16'hBEEF;
    mem[16'h01FE] = 16'h5555;
    mem[16'h5555] = 16'h7777;

    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'd0);

    @(negedge clk);
    check("rst_busy",      16'(busy),    16'd0);
    check("rst_done",      16'(done),    16'd0);
    check("rst_rf_we",     16'(rf_we),   16'd0);
    check("rst_mem_req",   16'(mem_req), 16'd0);
    check("rst_is_reg",    16'(is_reg),  16'd0);
    check("rst_opnd_addr", opnd_addr,    16'd0);
    check("rst_opnd_val",  opnd_val,     16'd0);
    check("rst_mem_addr",  mem_addr,     16'd0);
    check("rst_rf_w",      rf_w,         16'd0);
    check("rst_rf_sel",    16'(rf_sel),  16'd0);
    reset = 1'b0;

    // Mode 0 (register), fetch set but no memory traffic expected.
    set_reg(3'd3, 16'h1234);
    r0 = req_cycles;
    run_op(6'o03, 1'b0, 1'b1, 0, lat);
    $display("[TB] mode0 R3 lat=%0d val=%h is_reg=%b", lat, opnd_val, is_reg);
    check("m0_latency",  16'(lat),    16'd2);
    check("m0_val",      opnd_val,    16'h1234);
    check("m0_is_reg",   16'(is_reg), 16'd1);
    check("m0_addr",     opnd_addr,   16'd0);
    check("m0_no_req",   16'(req_cycles - r0), 16'd0);
    @(negedge clk);
    check("m0_done_pulse", 16'(done), 16'd0);
    check("m0_idle",       16'(busy), 16'd0);
    check("m0_val_hold",   opnd_val,  16'h1234);

    // Mode 1 (deferred register), no fetch.
    set_reg(3'd1, 16'h4000);
    run_op(6'o11, 1'b0, 1'b0, 0, lat);
    $display("[TB] mode1 R1 lat=%0d addr=%h val=%h", lat, opnd_addr, opnd_val);
    check("m1_latency", 16'(lat),    16'd2);
    check("m1_addr",    opnd_addr,   16'h4000);
    check("m1_val",     opnd_val,    16'd0);
    check("m1_is_reg",  16'(is_reg), 16'd0);

    // Mode 2 byte on R5 at 0xFFFF: step 1 wraps to 0x0000.
    set_reg(3'd5, 16'hFFFF);
    w0 = we_count;
    run_op(6'o25, 1'b1, 1'b1, 0, lat);
    $display("[TB] mode2 R5 lat=%0d R5=%h addr=%h val=%h", lat, regs[5], opnd_addr, opnd_val);
    check("m2_latency",  16'(lat),         16'd5);
    check("m2_r5",       regs[5],          16'h0000);
    check("m2_mem_addr", last_ack_addr,    16'hFFFF);
    check("m2_addr",     opnd_addr,        16'hFFFF);
    check("m2_val",      opnd_val,         16'hA5A5);
    check("m2_writes",   16'(we_count - w0), 16'd1);

    // Mode 4 byte on SP: SP still steps by 2.
    set_reg(3'd6, 16'h0100);
    run_op(6'o46, 1'b1, 1'b0, 0, lat);
    $display("[TB] mode4 SP lat=%0d R6=%h addr=%h", lat, regs[6], opnd_addr);
    check("m4_latency", 16'(lat),  16'd3);
    check("m4_r6",      regs[6],   16'h00FE);
    check("m4_addr",    opnd_addr, 16'h00FE);
    check("m4_val",     opnd_val,  16'd0);

    // Mode 4 word on R0=0: wraps to 0xFFFE.
    set_reg(3'd0, 16'h0000);
    run_op(6'o40, 1'b0, 1'b0, 0, lat);
    $display("[TB] mode4 R0 lat=%0d R0=%h addr=%h", lat, regs[0], opnd_addr);
    check("m4w_r0",   regs[0],   16'hFFFE);
    check("m4w_addr", opnd_addr, 16'hFFFE);

    // Mode 6 on PC with a 3-cycle ack delay.
    set_reg(3'd7, 16'h1000);
    ack_delay = 3;
    u0 = unstable;
    r0 = req_cycles;
    run_op(6'o67, 1'b0, 1'b0, 0, lat);
    ack_delay = 0;
    $display("[TB] mode6 PC lat=%0d R7=%h addr=%h", lat, regs[7], opnd_addr);
    check("m6_latency",  16'(lat),              16'd8);
    check("m6_r7",       regs[7],               16'h1002);
    check("m6_addr",     opnd_addr,             16'h1012);
    check("m6_stable",   16'(unstable - u0),    16'd0);
    check("m6_req_held", 16'(req_cycles - r0),  16'd4);

    // Mode 3 on R2 with fetch; a second start mid-operation must be ignored.
    set_reg(3'd2, 16'h2000);
    w0 = we_count;
    run_op(6'o32, 1'b0, 1'b1, 3, lat);
    $display("[TB] mode3 R2 lat=%0d R2=%h addr=%h val=%h", lat, regs[2], opnd_addr, opnd_val);
    check("m3_latency", 16'(lat),  16'd7);
    check("m3_r2",      regs[2],   16'h2002);
    check("m3_addr",    opnd_addr, 16'h3000);
    check("m3_val",     opnd_val,  16'hBEEF);
    @(negedge clk);
    @(negedge clk);
    check("m3_no_restart", 16'(busy),          16'd0);
    check("m3_r2_once",    16'(we_count - w0), 16'd1);

    // Mode 5 on R4 with fetch and a 1-cycle ack delay.
    set_reg(3'd4, 16'h0200);
    ack_delay = 1;
    run_op(6'o54, 1'b0, 1'b1, 0, lat);
    ack_delay = 0;
    $display("[TB] mode5 R4 lat=%0d R4=%h addr=%h val=%h", lat, regs[4], opnd_addr, opnd_val);
    check("m5_latency", 16'(lat),  16'd9);
    check("m5_r4",      regs[4],   16'h01FE);
    check("m5_addr",    opnd_addr, 16'h5555);
    check("m5_val",     opnd_val,  16'h7777);

    // Mode 7 on PC, reset while the index read is outstanding.
    set_reg(3'd7, 16'h1000);
    ack_delay = 5;
    w0 = we_count;
    @(negedge clk);
    spec  = 6'o77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("m7_req_raised", 16'(mem_req), 16'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] mode7 reset busy=%b mem_req=%b rf_we=%b", busy, mem_req, rf_we);
    check("m7_rst_busy",  16'(busy),    16'd0);
    check("m7_rst_req",   16'(mem_req), 16'd0);
    check("m7_rst_rf_we", 16'(rf_we),   16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    ack_delay = 0;
    check("m7_r7_kept", regs[7],            16'h1000);
    check("m7_no_wb",   16'(we_count - w0), 16'd0);
    check("m7_idle",    16'(busy),          16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
